// File: rtl/n64_reply_sequencer_if.sv
// Decoder- and pak-side signals of the N64 reply sequencer, grouped for binding.
// Pak handshake: pak_req is a one-cycle request for the next byte; the source answers at any later
// time with a one-cycle pak_valid carrying pak_byte; valid pulses without an outstanding request are dropped.
interface n64_reply_sequencer_if;
    logic [4:0]  response;
    logic [31:0] buttons;
    logic [7:0]  status_byte;
    logic        pak_req;
    logic [7:0]  pak_byte;
    logic        pak_valid;
    logic [7:0]  pak_crc;
    logic        busy;
    logic        done;
    logic        underrun;

    modport master (
        output response, buttons, status_byte, pak_byte, pak_valid, pak_crc,
        input  pak_req, busy, done, underrun
    );

    modport slave (
        input  response, buttons, status_byte, pak_byte, pak_valid, pak_crc,
        output pak_req, busy, done, underrun
    );
endinterface

// File: rtl/n64_reply_sequencer.sv
// Serialises a joybus reply (buttons, status, pak stream, CRC) as open-drain pulse-width bits
// after bus turnaround; state is exposed on dbg_state.
module n64_reply_sequencer #(
    parameter int CLK_PER_US = 48,
    parameter int TURN_US    = 2,
    parameter int PAK_BYTES  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  data_in,
    output logic                  data_oe,
    output logic [2:0]            dbg_state,
    n64_reply_sequencer_if.slave  bus
);
    localparam int TURN_CYC = TURN_US * CLK_PER_US;
    localparam int TW       = $clog2(3 * CLK_PER_US + 1);
    localparam int CW       = $clog2(TURN_CYC + 1);

    localparam logic [TW-1:0] T_SHORT  = TW'(CLK_PER_US - 1);
    localparam logic [TW-1:0] T_LONG   = TW'(3 * CLK_PER_US - 1);
    localparam logic [TW-1:0] T_STOP   = TW'(2 * CLK_PER_US - 1);
    localparam logic [CW-1:0] TURN_END = CW'(TURN_CYC - 1);
    localparam logic [5:0]    PAK_LAST = 6'(PAK_BYTES - 1);
    localparam logic [5:0]    PAK_CRC  = 6'(PAK_BYTES);

    typedef enum logic [2:0] {S_IDLE, S_TURN, S_LOW, S_HIGH, S_STOP} state_t;
    typedef enum logic [1:0] {SRC_BTN, SRC_STAT, SRC_PAK, SRC_CRC} src_t;

    state_t      state_q, state_d;
    src_t        src_q, src_d;
    logic        sync1_q, sync1_d, sync2_q, sync2_d;
    logic [4:0]  last_code_q, last_code_d;
    logic [CW-1:0] tcnt_q, tcnt_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [5:0]  byte_cnt_q, byte_cnt_d;
    logic [5:0]  last_byte_q, last_byte_d;
    logic [31:0] sh_q, sh_d;
    logic [7:0]  pak_buf_q, pak_buf_d;
    logic        pak_have_q, pak_have_d;
    logic        pak_wait_q, pak_wait_d;
    logic        data_oe_q, data_oe_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        pak_req_q, pak_req_d;
    logic        underrun_q, underrun_d;

    logic        code_ok;
    src_t        code_src;
    logic [5:0]  code_last;
    logic [7:0]  pak_next;

    function automatic logic [TW-1:0] low_len(input logic b);
        return b ? T_SHORT : T_LONG;
    endfunction

    function automatic logic [TW-1:0] high_len(input logic b);
        return b ? T_LONG : T_SHORT;
    endfunction

    // A missing pak byte goes out as zero; the caller flags the underrun.
    assign pak_next = pak_have_q ? pak_buf_q : 8'h00;

    always_comb begin
        code_ok   = 1'b1;
        code_src  = SRC_BTN;
        code_last = 6'd0;
        case (bus.response)
            5'b10001: begin code_src = SRC_BTN;  code_last = 6'd3;    end
            5'b10010: begin code_src = SRC_STAT; code_last = 6'd2;    end
            5'b10011, 5'b10100,
            5'b10101, 5'b10110: begin code_src = SRC_PAK; code_last = PAK_CRC; end
            5'b10111: begin code_src = SRC_CRC;  code_last = 6'd0;    end
            default:  code_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        sync1_d     = data_in;
        sync2_d     = sync1_q;
        last_code_d = last_code_q;
        tcnt_d      = tcnt_q;
        timer_d     = timer_q;
        bit_cnt_d   = bit_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        last_byte_d = last_byte_q;
        sh_d        = sh_q;
        pak_buf_d   = pak_buf_q;
        pak_have_d  = pak_have_q;
        pak_wait_d  = pak_wait_q;
        data_oe_d   = data_oe_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        pak_req_d   = 1'b0;
        underrun_d  = underrun_q;

        if (bus.pak_valid && pak_wait_q) begin
            pak_buf_d  = bus.pak_byte;
            pak_have_d = 1'b1;
            pak_wait_d = 1'b0;
        end

        if (bus.response == 5'b00000) begin
            last_code_d = 5'b00000;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.response[4] && (bus.response != last_code_q) && code_ok) begin
                    last_code_d = bus.response;
                    state_d     = S_TURN;
                    busy_d      = 1'b1;
                    tcnt_d      = '0;
                    bit_cnt_d   = 3'd0;
                    byte_cnt_d  = 6'd0;
                    src_d       = code_src;
                    last_byte_d = code_last;
                    pak_have_d  = 1'b0;
                    pak_wait_d  = 1'b0;
                    case (code_src)
                        SRC_BTN:  sh_d = bus.buttons;
                        SRC_STAT: sh_d = {8'h05, 8'h00, bus.status_byte, 8'h00};
                        default:  sh_d = 32'h0;
                    endcase
                    // Byte 0 is requested at acceptance so it is in hand when turnaround ends.
                    if (code_src == SRC_PAK) begin
                        pak_req_d  = 1'b1;
                        pak_wait_d = 1'b1;
                    end
                end
            end

            S_TURN: begin
                if (!sync2_q) begin
                    tcnt_d = '0;
                end else if (tcnt_q == TURN_END) begin
                    if (src_q == SRC_PAK) begin
                        sh_d       = {pak_next, 24'h0};
                        underrun_d = underrun_q | ~pak_have_q;
                        pak_have_d = 1'b0;
                        pak_wait_d = 1'b0;
                    end else if (src_q == SRC_CRC) begin
                        sh_d = {bus.pak_crc, 24'h0};
                    end
                    state_d   = S_LOW;
                    data_oe_d = 1'b1;
                    timer_d   = low_len(sh_d[31]);
                end else begin
                    tcnt_d = tcnt_q + CW'(1);
                end
            end

            S_LOW: begin
                if (timer_q == '0) begin
                    state_d   = S_HIGH;
                    data_oe_d = 1'b0;
                    timer_d   = high_len(sh_q[31]);
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end

            S_HIGH: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - TW'(1);
                end else if ((bit_cnt_q == 3'd7) && (byte_cnt_q == last_byte_q)) begin
                    state_d   = S_STOP;
                    data_oe_d = 1'b1;
                    timer_d   = T_STOP;
                end else begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    sh_d      = {sh_q[30:0], 1'b0};
                    if (bit_cnt_q == 3'd7) begin
                        byte_cnt_d = byte_cnt_q + 6'd1;
                        if (src_q == SRC_PAK) begin
                            if (byte_cnt_q == PAK_LAST) begin
                                sh_d[31:24] = bus.pak_crc;
                            end else begin
                                sh_d[31:24] = pak_next;
                                underrun_d  = underrun_q | ~pak_have_q;
                                pak_have_d  = 1'b0;
                                pak_wait_d  = 1'b0;
                            end
                        end
                    end
                    // Entering the last bit of a byte: ask for the following pak byte.
                    if ((src_q == SRC_PAK) && (bit_cnt_q == 3'd6) && (byte_cnt_q < PAK_LAST)) begin
                        pak_req_d  = 1'b1;
                        pak_wait_d = 1'b1;
                    end
                    state_d   = S_LOW;
                    data_oe_d = 1'b1;
                    timer_d   = low_len(sh_d[31]);
                end
            end

            S_STOP: begin
                if (timer_q == '0) begin
                    state_d   = S_IDLE;
                    data_oe_d = 1'b0;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end

            default: begin
                state_d   = S_IDLE;
                data_oe_d = 1'b0;
                busy_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            src_q       <= SRC_BTN;
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            last_code_q <= 5'b00000;
            tcnt_q      <= '0;
            timer_q     <= '0;
            bit_cnt_q   <= 3'd0;
            byte_cnt_q  <= 6'd0;
            last_byte_q <= 6'd0;
            sh_q        <= 32'h0;
            pak_buf_q   <= 8'h00;
            pak_have_q  <= 1'b0;
            pak_wait_q  <= 1'b0;
            data_oe_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pak_req_q   <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            last_code_q <= last_code_d;
            tcnt_q      <= tcnt_d;
            timer_q     <= timer_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            last_byte_q <= last_byte_d;
            sh_q        <= sh_d;
            pak_buf_q   <= pak_buf_d;
            pak_have_q  <= pak_have_d;
            pak_wait_q  <= pak_wait_d;
            data_oe_q   <= data_oe_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pak_req_q   <= pak_req_d;
            underrun_q  <= underrun_d;
        end
    end

    assign data_oe      = data_oe_q;
    assign dbg_state    = state_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.pak_req  = pak_req_q;
    assign bus.underrun = underrun_q;
endmodule
